// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue register: opcodes, issue FSM states and the bypass bus type.
package alu_issue_pkg;

    localparam int ISS_XLEN   = 32;
    localparam int ISS_REG_AW = 5;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_SLTU,
        OP_OUT1
    } opcode_t;

    typedef enum logic [1:0] {
        ISS_EMPTY,
        ISS_WAIT,
        ISS_READY
    } issue_state_t;

    // Common shape of the EX and WB bypass ports; ok=0 marks a load result not yet available.
    typedef struct packed {
        logic                  valid;
        logic [ISS_REG_AW-1:0] dest;
        logic [ISS_XLEN-1:0]   data;
        logic                  ok;
    } fwd_bus_t;

endpackage

// File: rtl/alu_issue_operand_bypass.sv
// Resolves one register operand against the EX and WB bypass buses, falling back to the register file.
module operand_bypass
    import alu_issue_pkg::*;
(
    input  logic [ISS_REG_AW-1:0] addr,
    input  logic [ISS_XLEN-1:0]   rf_data,
    input  fwd_bus_t              ex,
    input  fwd_bus_t              wb,
    output logic [ISS_XLEN-1:0]   value,
    output logic                  pending,
    output logic                  hit
);

    logic ex_match;
    logic wb_match;

    assign ex_match = ex.valid && (ex.dest == addr);
    assign wb_match = wb.valid && (wb.dest == addr);

    // EX holds the younger producer, so a matching but unready EX entry blocks a WB match.
    always_comb begin
        value   = '0;
        pending = 1'b0;
        hit     = 1'b0;
        if (addr == '0) begin
            value = '0;
        end else if (ex_match) begin
            if (ex.ok) begin
                value = ex.data;
                hit   = 1'b1;
            end else begin
                pending = 1'b1;
            end
        end else if (wb_match) begin
            value = wb.data;
            hit   = 1'b1;
        end else begin
            value = rf_data;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue register in front of the ALU with EX/WB operand bypass and load-use stalling.
// Optional ALU_ISSUE_PERF_EN adds a perf_wait_cycles counter of cycles spent waiting on operands.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN   = ISS_XLEN,
    parameter int REG_AW = ISS_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  opcode_t           in_op,
    input  logic [REG_AW-1:0] in_rj,
    input  logic [REG_AW-1:0] in_rk,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_use_pc,
    input  logic              in_use_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              ex_fwd_valid,
    input  logic [REG_AW-1:0] ex_fwd_dest,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_fwd_ok,
    input  logic              wb_fwd_valid,
    input  logic [REG_AW-1:0] wb_fwd_dest,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output opcode_t           out_op,
    output logic [XLEN-1:0]   out_src1,
    output logic [XLEN-1:0]   out_src2,
    output logic [REG_AW-1:0] out_rd
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_wait_cycles
`endif
);

    issue_state_t      state;
    logic              pend1;
    logic              pend2;
    logic [REG_AW-1:0] hold_rj;
    logic [REG_AW-1:0] hold_rk;

    fwd_bus_t          ex_bus;
    fwd_bus_t          wb_bus;
    logic [REG_AW-1:0] sel_rj;
    logic [REG_AW-1:0] sel_rk;
    logic [XLEN-1:0]   b1_value;
    logic [XLEN-1:0]   b2_value;
    logic              b1_pend;
    logic              b2_pend;
    logic              b1_hit;
    logic              b2_hit;

    logic [XLEN-1:0]   acc_src1;
    logic [XLEN-1:0]   acc_src2;
    logic              acc_pend1;
    logic              acc_pend2;
    logic              accept;

    assign ex_bus = '{valid: ex_fwd_valid, dest: ex_fwd_dest, data: ex_fwd_data, ok: ex_fwd_ok};
    assign wb_bus = '{valid: wb_fwd_valid, dest: wb_fwd_dest, data: wb_fwd_data, ok: 1'b1};

    assign rf_raddr1 = in_rj;
    assign rf_raddr2 = in_rk;

    assign in_ready  = !flush && ((state == ISS_EMPTY) || ((state == ISS_READY) && out_ready));
    assign out_valid = (state == ISS_READY);
    assign accept    = in_valid && in_ready;

    // While waiting, the same resolvers watch the buses for the stored source registers.
    assign sel_rj = (state == ISS_WAIT) ? hold_rj : in_rj;
    assign sel_rk = (state == ISS_WAIT) ? hold_rk : in_rk;

    operand_bypass u_bypass1 (
        .addr    (sel_rj),
        .rf_data (rf_rdata1),
        .ex      (ex_bus),
        .wb      (wb_bus),
        .value   (b1_value),
        .pending (b1_pend),
        .hit     (b1_hit)
    );

    operand_bypass u_bypass2 (
        .addr    (sel_rk),
        .rf_data (rf_rdata2),
        .ex      (ex_bus),
        .wb      (wb_bus),
        .value   (b2_value),
        .pending (b2_pend),
        .hit     (b2_hit)
    );

    always_comb begin
        acc_src1  = in_use_pc  ? in_pc  : b1_value;
        acc_src2  = in_use_imm ? in_imm : b2_value;
        acc_pend1 = !in_use_pc  && b1_pend;
        acc_pend2 = !in_use_imm && b2_pend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ISS_EMPTY;
            pend1    <= 1'b0;
            pend2    <= 1'b0;
            hold_rj  <= '0;
            hold_rk  <= '0;
            out_op   <= OP_OUT1;
            out_src1 <= '0;
            out_src2 <= '0;
            out_rd   <= '0;
        end else if (flush) begin
            state <= ISS_EMPTY;
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else if (accept) begin
            out_op   <= in_op;
            out_rd   <= in_rd;
            out_src1 <= acc_src1;
            out_src2 <= acc_src2;
            hold_rj  <= in_rj;
            hold_rk  <= in_rk;
            pend1    <= acc_pend1;
            pend2    <= acc_pend2;
            state    <= (acc_pend1 || acc_pend2) ? ISS_WAIT : ISS_READY;
        end else begin
            case (state)
                ISS_WAIT: begin
                    if (pend1 && b1_hit) begin
                        out_src1 <= b1_value;
                        pend1    <= 1'b0;
                    end
                    if (pend2 && b2_hit) begin
                        out_src2 <= b2_value;
                        pend2    <= 1'b0;
                    end
                    if ((!pend1 || b1_hit) && (!pend2 || b2_hit)) begin
                        state <= ISS_READY;
                    end
                end
                ISS_READY: begin
                    if (out_ready) begin
                        state <= ISS_EMPTY;
                    end
                end
                ISS_EMPTY: begin
                    state <= ISS_EMPTY;
                end
                default: begin
                    state <= ISS_EMPTY;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Survives flush on purpose so stall statistics span pipeline redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wait_cycles <= '0;
        end else if (state == ISS_WAIT) begin
            perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table for single-issue resolution plus hand-written stall/flush sequences.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    opcode_t     in_op;
    logic [4:0]  in_rj, in_rk, in_rd;
    logic        in_use_pc, in_use_imm;
    logic [31:0] in_pc, in_imm;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_fwd_valid, ex_fwd_ok;
    logic [4:0]  ex_fwd_dest;
    logic [31:0] ex_fwd_data;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_dest;
    logic [31:0] wb_fwd_data;
    logic        out_valid, out_ready;
    opcode_t     out_op;
    logic [31:0] out_src1, out_src2;
    logic [4:0]  out_rd;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_wait_cycles;
`endif

    int checks = 0;
    int errors = 0;

    alu_issue dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rj        (in_rj),
        .in_rk        (in_rk),
        .in_rd        (in_rd),
        .in_use_pc    (in_use_pc),
        .in_use_imm   (in_use_imm),
        .in_pc        (in_pc),
        .in_imm       (in_imm),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .ex_fwd_valid (ex_fwd_valid),
        .ex_fwd_dest  (ex_fwd_dest),
        .ex_fwd_data  (ex_fwd_data),
        .ex_fwd_ok    (ex_fwd_ok),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_fwd_dest  (wb_fwd_dest),
        .wb_fwd_data  (wb_fwd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_src1     (out_src1),
        .out_src2     (out_src2),
        .out_rd       (out_rd)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        opcode_t     op;
        logic [4:0]  rj, rk, rd;
        logic        use_pc, use_imm;
        logic [31:0] pc, imm, rf1, rf2;
        fwd_bus_t    ex, wb;
        logic [31:0] exp1, exp2;
    } vec_t;

    vec_t vecs[8];

    function automatic fwd_bus_t mkFwd(input logic v, input logic [4:0] d, input logic [31:0] data, input logic ok);
        fwd_bus_t f;
        f.valid = v;
        f.dest  = d;
        f.data  = data;
        f.ok    = ok;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setFwd(input fwd_bus_t ex, input fwd_bus_t wb);
        ex_fwd_valid = ex.valid;
        ex_fwd_dest  = ex.dest;
        ex_fwd_data  = ex.data;
        ex_fwd_ok    = ex.ok;
        wb_fwd_valid = wb.valid;
        wb_fwd_dest  = wb.dest;
        wb_fwd_data  = wb.data;
    endtask

    task automatic driveInstr(input opcode_t op, input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] rd,
                              input logic [31:0] rf1, input logic [31:0] rf2);
        in_op      = op;
        in_rj      = rj;
        in_rk      = rk;
        in_rd      = rd;
        in_use_pc  = 1'b0;
        in_use_imm = 1'b0;
        rf_rdata1  = rf1;
        rf_rdata2  = rf2;
        in_valid   = 1'b1;
    endtask

    task automatic clearFwd();
        setFwd(mkFwd(1'b0, 5'd0, 32'h0, 1'b0), mkFwd(1'b0, 5'd0, 32'h0, 1'b0));
    endtask

    // Issue one vector from EMPTY, check the resolved operands, then drain it.
    task automatic applyStimulus(input int idx, input vec_t v);
        driveInstr(v.op, v.rj, v.rk, v.rd, v.rf1, v.rf2);
        in_use_pc  = v.use_pc;
        in_use_imm = v.use_imm;
        in_pc      = v.pc;
        in_imm     = v.imm;
        setFwd(v.ex, v.wb);
        out_ready  = 1'b0;
        #1;
        checkOutput($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        clearFwd();
        rf_rdata1 = 32'hDEAD_0001;
        rf_rdata2 = 32'hDEAD_0002;
        checkOutput($sformatf("v%0d out_valid", idx), {31'b0, out_valid}, 32'd1);
        checkOutput($sformatf("v%0d src1", idx), out_src1, v.exp1);
        checkOutput($sformatf("v%0d src2", idx), out_src2, v.exp2);
        checkOutput($sformatf("v%0d rd", idx), {27'b0, out_rd}, {27'b0, v.rd});
        checkOutput($sformatf("v%0d op", idx), 32'(out_op), 32'(v.op));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput($sformatf("v%0d drained", idx), {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_ADD,  5'd3, 5'd4, 5'd9,  1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 32'd7,
                    mkFwd(0, 5'd0, 32'h0, 0), mkFwd(0, 5'd0, 32'h0, 0), 32'd5, 32'd7};
        vecs[1] = '{OP_ADD,  5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 32'd7,
                    mkFwd(1, 5'd3, 32'h10, 1), mkFwd(1, 5'd3, 32'h20, 0), 32'h10, 32'd7};
        vecs[2] = '{OP_SUB,  5'd3, 5'd4, 5'd11, 1'b0, 1'b0, 32'h0, 32'h0, 32'd5, 32'd7,
                    mkFwd(0, 5'd0, 32'h0, 0), mkFwd(1, 5'd4, 32'h44, 0), 32'd5, 32'h44};
        vecs[3] = '{OP_OR,   5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 32'h55,
                    mkFwd(1, 5'd0, 32'h77, 1), mkFwd(1, 5'd0, 32'h88, 0), 32'h0, 32'h0};
        vecs[4] = '{OP_XOR,  5'd2, 5'd4, 5'd13, 1'b0, 1'b1, 32'h0, 32'hFFFF_F000, 32'h123, 32'h7,
                    mkFwd(1, 5'd4, 32'hBAD, 0), mkFwd(0, 5'd0, 32'h0, 0), 32'h123, 32'hFFFF_F000};
        vecs[5] = '{OP_AND,  5'd5, 5'd6, 5'd14, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h5, 32'h6,
                    mkFwd(1, 5'd5, 32'h0, 0), mkFwd(1, 5'd6, 32'h66, 0), 32'h1000, 32'h66};
        vecs[6] = '{OP_SLT,  5'd7, 5'd8, 5'd15, 1'b0, 1'b0, 32'h0, 32'h0, 32'h70, 32'h80,
                    mkFwd(1, 5'd8, 32'h8888, 1), mkFwd(1, 5'd7, 32'h77, 0), 32'h77, 32'h8888};
        vecs[7] = '{OP_SRL,  5'd9, 5'd9, 5'd1,  1'b0, 1'b0, 32'h0, 32'h0, 32'h90, 32'h90,
                    mkFwd(0, 5'd9, 32'hEEEE, 1), mkFwd(0, 5'd9, 32'hFFFF, 0), 32'h90, 32'h90};

        reset = 1'b1;
        flush = 1'b0;
        driveInstr(OP_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        in_valid = 1'b0;
        in_pc = 32'h0;
        in_imm = 32'h0;
        out_ready = 1'b0;
        clearFwd();
        @(negedge clk);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset out_op", 32'(out_op), 32'(OP_OUT1));
        checkOutput("reset src1", out_src1, 32'h0);
        checkOutput("reset src2", out_src2, 32'h0);
        checkOutput("reset rd", {27'b0, out_rd}, 32'h0);
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        checkOutput("reset perf", perf_wait_cycles, 32'd0);
`endif
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] load-use sequence");
        driveInstr(OP_ADD, 5'd3, 5'd4, 5'd2, 32'd5, 32'd0);
        setFwd(mkFwd(1, 5'd4, 32'hDEAD, 0), mkFwd(0, 5'd0, 32'h0, 0));
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        clearFwd();
        rf_rdata1 = 32'hBEEF;
        #1;
        checkOutput("lu wait1 out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("lu wait1 in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        setFwd(mkFwd(1, 5'd4, 32'h1111, 0), mkFwd(1, 5'd9, 32'h9999, 0));
        checkOutput("lu wait2 out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        setFwd(mkFwd(0, 5'd0, 32'h0, 0), mkFwd(1, 5'd4, 32'hABCD, 0));
        checkOutput("lu wait3 out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        clearFwd();
        checkOutput("lu out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("lu src1", out_src1, 32'd5);
        checkOutput("lu src2", out_src2, 32'hABCD);
`ifdef ALU_ISSUE_PERF_EN
        checkOutput("lu perf", perf_wait_cycles, 32'd3);
`endif
        tick();
        checkOutput("lu drained", {31'b0, out_valid}, 32'd0);

        $display("[TB] backpressure and back-to-back");
        out_ready = 1'b0;
        driveInstr(OP_SUB, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22);
        tick();
        driveInstr(OP_AND, 5'd3, 5'd4, 5'd6, 32'h33, 32'h44);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("bp%0d out_valid", c), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("bp%0d in_ready", c), {31'b0, in_ready}, 32'd0);
            checkOutput($sformatf("bp%0d src1", c), out_src1, 32'h11);
            checkOutput($sformatf("bp%0d src2", c), out_src2, 32'h22);
            checkOutput($sformatf("bp%0d rd", c), {27'b0, out_rd}, 32'd5);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("b2b in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("b2b out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("b2b src1", out_src1, 32'h33);
        checkOutput("b2b src2", out_src2, 32'h44);
        checkOutput("b2b rd", {27'b0, out_rd}, 32'd6);
        checkOutput("b2b op", 32'(out_op), 32'(OP_AND));
        tick();
        checkOutput("b2b drained", {31'b0, out_valid}, 32'd0);

        $display("[TB] flush during wait");
        driveInstr(OP_OR, 5'd1, 5'd6, 5'd7, 32'h1, 32'h0);
        setFwd(mkFwd(1, 5'd6, 32'h0, 0), mkFwd(0, 5'd0, 32'h0, 0));
        tick();
        in_valid = 1'b0;
        clearFwd();
        flush = 1'b1;
        #1;
        checkOutput("fl wait in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        setFwd(mkFwd(0, 5'd0, 32'h0, 0), mkFwd(1, 5'd6, 32'h66, 0));
        #1;
        checkOutput("fl wait out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("fl wait empty", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("fl stale wb1", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("fl stale wb2", {31'b0, out_valid}, 32'd0);
        clearFwd();

        $display("[TB] flush with in_valid");
        driveInstr(OP_XOR, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2);
        flush = 1'b1;
        #1;
        checkOutput("fl in in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl in out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("fl in still empty", {31'b0, out_valid}, 32'd0);

        $display("[TB] reset during wait");
        driveInstr(OP_ADD, 5'd10, 5'd11, 5'd12, 32'h10, 32'h11);
        setFwd(mkFwd(1, 5'd10, 32'h0, 0), mkFwd(0, 5'd0, 32'h0, 0));
        tick();
        in_valid = 1'b0;
        clearFwd();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setFwd(mkFwd(0, 5'd0, 32'h0, 0), mkFwd(1, 5'd10, 32'hAAAA, 0));
        checkOutput("rst wait out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst wait op", 32'(out_op), 32'(OP_OUT1));
        checkOutput("rst wait src1", out_src1, 32'h0);
`ifdef ALU_ISSUE_PERF_EN
        checkOutput("rst perf", perf_wait_cycles, 32'd0);
`endif
        tick();
        checkOutput("rst stale wb", {31'b0, out_valid}, 32'd0);
        clearFwd();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Single-entry issue register that sits directly upstream of the ALU. Accepts a decoded instruction from decode, reads its register operands, and resolves them against the EX and WB bypass sources. Holds the instruction while an operand waits on an in-flight load, then presents a fully resolved `op`/`src1`/`src2` to the ALU under a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `REG_AW`, 5: register address width.

Ports:
- `clk`  in  1  clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  discard the held instruction and any instruction offered this cycle.
- `in_valid` / `in_ready`  in / out  1  decode handshake.
- `in_op`  in  `opcode_t`  ALU operation.
- `in_rj`, `in_rk`, `in_rd`  in  `REG_AW`  source 1 register, source 2 register, destination register.
- `in_use_pc`, `in_use_imm`  in  1  select `in_pc` for src1 and `in_imm` for src2, respectively.
- `in_pc`, `in_imm`  in  `XLEN`  PC operand and immediate operand.
- `rf_raddr1`, `rf_raddr2`  out  `REG_AW`  register-file read addresses; driven combinationally from `in_rj` and `in_rk`.
- `rf_rdata1`, `rf_rdata2`  in  `XLEN`  combinational register-file read data.
- `ex_fwd_valid`, `ex_fwd_dest`, `ex_fwd_data`, `ex_fwd_ok`  in  1/`REG_AW`/`XLEN`/1  EX-stage producer; `ex_fwd_ok=0` means the value is not yet available (load).
- `wb_fwd_valid`, `wb_fwd_dest`, `wb_fwd_data`  in  1/`REG_AW`/`XLEN`  WB-stage producer; its data is always available.
- `out_valid` / `out_ready`  out / in  1  ALU handshake.
- `out_op`, `out_src1`, `out_src2`, `out_rd`  out  registered operation, operands and destination.

## Operation
- States: EMPTY, WAIT (at least one register operand pending), READY.
- `in_ready` = (state==EMPTY) || (state==READY && out_ready).
- `out_valid` = (state==READY).
- Operand resolution at accept, per source with address `a`:
  - `a==0` gives 0.
  - Otherwise, if `ex_fwd_valid && ex_fwd_dest==a`: take `ex_fwd_data` when `ex_fwd_ok`, else mark the operand pending.
  - Otherwise, if `wb_fwd_valid && wb_fwd_dest==a`: take `wb_fwd_data`.
  - Otherwise take the register-file data.
  - EX has priority over WB because it holds the younger producer.
- `in_use_pc` / `in_use_imm` override src1 / src2 respectively. An overridden operand is never pending.
- Accept transitions: go to WAIT if either operand is pending, else to READY.
- In WAIT, each cycle every pending operand re-checks EX (requires `ex_fwd_ok`) then WB against its stored register number. A hit captures the data and clears the pending flag.
- WAIT→READY on the edge at which the last pending flag clears.
- In READY with `out_ready=1` (fire):
  - if `in_valid` is also high, the next instruction is accepted the same cycle (back-to-back, no bubble);
  - otherwise go to EMPTY.
- Priority: `reset` > `flush` > handshake. `flush` forces EMPTY and clears pending flags. Input offered in the flush cycle is not accepted, and `in_ready` is forced to 0 during flush.
- Captured operand values never change in READY. Issue is in order, so no younger writer can appear.

## Timing
- Reset values: state EMPTY, `out_valid=0`, `out_op=OP_OUT1`, `out_src1=0`, `out_src2=0`, `out_rd=0`, all pending flags 0.
- Latency with no hazard: 1 cycle from accept to `out_valid`.
- Load-use: `out_valid` rises the cycle after the bypass source presents the data.
- Throughput: 1 instruction per cycle while `out_ready=1` and no hazards.
- `out_*` are held stable while `out_valid && !out_ready`.
- Reset or flush asserted mid-WAIT: the next cycle is EMPTY and no stale capture occurs.

## Configuration
- `ALU_ISSUE_PERF_EN` defined:
  - adds output `perf_wait_cycles` (32-bit) counting cycles spent in WAIT;
  - cleared by `reset` only, not by `flush`;
  - wraps 0xFFFFFFFF→0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared definitions package holds:
  - `opcode_t` (already defined there);
  - new `issue_state_t` enum {ISS_EMPTY, ISS_WAIT, ISS_READY};
  - a packed `fwd_bus_t` {valid, dest, data, ok} so both bypass ports share one type.
- Sub-module `operand_bypass` (combinational, instantiated twice):
  - inputs: register address, register-file data, EX bus, WB bus;
  - outputs: value and pending;
  - used both at accept and in WAIT.

## Test plan
- Basic issue: `reset`, then issue OP_ADD with rj=3 (rf=5) and rk=4 (rf=7), `out_ready=1`. Expect `out_valid` next cycle with src1=5, src2=7 and rd as issued.
- EX forward: `ex_fwd`={1, 3, 0x10, ok=1} while rf[3]=5 and `wb_fwd` also targets r3 with 0x20. Expect src1=0x10 (EX wins).
- Load-use: `ex_fwd`={1, 4, x, ok=0} at accept. Expect WAIT with no `out_valid`. Two cycles later `wb_fwd`={1, 4, 0xABCD}. Expect `out_valid` the following cycle with src2=0xABCD; with `ALU_ISSUE_PERF_EN`, `perf_wait_cycles`=3.
- Zero/immediate: rj=0 with `ex_fwd_dest`=0 gives src1=0. `in_use_imm=1`, imm=0xFFFFF000, with rk hazarded by a pending load gives READY directly and src2=0xFFFFF000.
- Backpressure and back-to-back: hold `out_ready=0` for 3 cycles and check `out_*` stable and `in_ready=0`. Raise `out_ready` with `in_valid=1` and check fire and accept in the same cycle, with the new `out_valid` following immediately.
- Flush: flush during WAIT, and also flush coincident with `in_valid`. Expect EMPTY next cycle, `out_valid=0`, nothing accepted. A later WB match for the old register produces no output.
